fetch_queue_unit: RTL and testbench
===================================

Name: fetch_queue_unit

Overview:
- Parametrised instruction-fetch stage for the pipelined MIPS core; successor to the single-cycle fetch.
- Holds the word-addressed PC and drives a combinational instruction ROM.
- Buffers fetched words in a DEPTH-entry prefetch queue and hands them to decode over a valid/ready handshake.
- Accepts late-resolved jump/branch redirects, computes the target internally and flushes the queue.

Parameters:
- PC_W, 30, word-address PC width; must be >= 26.
- DEPTH, 4, prefetch queue entries; power of two, >= 2.
- RESET_PC, 0, word address loaded on reset.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- imem_addr  out  PC_W+2  byte address to ROM, {pc, 2'b00}
- imem_data  in  32  combinational ROM read data for imem_addr
- out_valid  out  1  head entry available to decode
- out_ready  in  1  decode accepts head entry
- out_instr  out  32  head instruction
- out_pc_seq  out  PC_W  head instruction's word PC + 1
- redir_valid  in  1  redirect request from a later stage
- redir_is_jump  in  1  1 = jump target, 0 = branch target
- redir_pc_seq  in  PC_W  pc_seq of the redirecting instruction
- redir_imm16  in  16  branch offset in words
- redir_addr26  in  26  jump field
- occupancy  out  $clog2(DEPTH)+1  current queue entry count

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: pc=RESET_PC; queue empty; occupancy=0; out_valid=0; out_instr=0; out_pc_seq=0.
- Reset asserted mid-operation discards all queued entries immediately.
- Fetch: each cycle with no redirect and (queue not full, or full with a pop this cycle):
  - push {pc+1, imem_data};
  - pc <= next_pc, where next_pc = pc+1, wrapping modulo 2^PC_W.
- Full and no pop: no push, pc holds, imem_addr stable.
- Output: out_valid = occupancy != 0. out_instr and out_pc_seq show the head entry and are held stable while out_valid && !out_ready.
- Pop: occurs on out_valid && out_ready.
- Push and pop in the same cycle: occupancy unchanged.
- Pointers wrap at DEPTH.
- Latency: word fetched in cycle N appears at the head no earlier than cycle N+1.
- Redirect has priority over fetch:
  - A handshake completing in the redirect cycle counts as consumed.
  - The rest of the queue is flushed; occupancy=0 next cycle; no push that cycle.
  - pc <= target.
  - The target word is fetched in N+1, and out_valid is 1 at N+2 at the earliest.
- Targets:
  - Branch: redir_pc_seq + sext(redir_imm16) to PC_W, modulo 2^PC_W.
  - Jump: {redir_pc_seq[PC_W-1:26], redir_addr26}; when PC_W == 26, just redir_addr26.
- Redirect while the queue is empty or full: same flush behaviour.
- Back-to-back redirects: the last one wins, and each one flushes.

Optional Feature:
- JUMP_PREDECODE_EN, when defined:
  - If imem_data[31:26] == OP_J and the word is pushed, next_pc = {pc[PC_W-1:26], imem_data[25:0]} instead of pc+1.
  - The J instruction itself is still queued with pc_seq = pc+1.
  - An external redirect in the same cycle overrides predecode.
- When undefined: next_pc is always pc+1, and J is resolved only through redirect.

Decomposition:
- Shared package mips_pkg:
  - opcode constants OP_J=6'b000010, OP_BEQ=6'b000100;
  - default PC_W;
  - instruction field index constants (opcode, addr26, imm16 ranges).
- One sub-module, fetch_fifo: synchronous DEPTH x (32+PC_W) FIFO with push, pop, flush, full, empty and count; asynchronous active-low reset.
- Target arithmetic and PC register stay in the top.

Test Plan:
- Reset release, RESET_PC=0, out_ready=1, ROM word k = k:
  - imem_addr 0,4,8,…;
  - out_instr 0,1,2,… with out_pc_seq 1,2,3,…;
  - out_valid first high the cycle after reset release.
- out_ready=0 for 10 cycles, DEPTH=4:
  - occupancy reaches 4, pc holds at 4, head stays instr 0;
  - after ready=1, instrs 1..3 follow with no loss or duplication.
- Queue holding 3 entries, redir_valid with is_jump=0, pc_seq=0x10, imm16=0xFFFE:
  - occupancy 0 next cycle;
  - imem_addr = 0x38 (word 0x0E);
  - first output has out_pc_seq = 0x0F.
- Jump redirect, pc_seq=0x3FFFFFFF, addr26=0x0000005:
  - target {4'hF, 26'h5} = 0x3C000005.
- PC at 0x3FFFFFFF, no redirect:
  - next fetch at word 0; out_pc_seq for that word = 0;
  - simultaneous redirect + pop in the same cycle: popped entry consumed, target fetched next.
- With JUMP_PREDECODE_EN, ROM word 2 = 0x08000010:
  - fetch sequence 0,1,2,0x10;
  - J entry out_pc_seq = 3;
  - without the macro: sequence 0,1,2,3.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, instruction field positions, default PC width.
// Latency: none (constants only).
// Backpressure: not applicable.
package mips_pkg;

    // Word-addressed PC width used when a block does not override it.
    localparam int PC_W_DEFAULT = 30;

    // Opcodes the fetch path cares about.
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BEQ = 6'b000100;

    // Instruction field bit ranges.
    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int ADDR26_HI = 25;
    localparam int ADDR26_LO = 0;
    localparam int IMM16_HI  = 15;
    localparam int IMM16_LO  = 0;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO with flush and occupancy count.
// Latency: a word pushed at edge N is at the head after edge N (visible in cycle N+1).
// Backpressure: push is ignored when full unless a pop happens in the same cycle; pop ignored when empty.
module fetch_fifo import mips_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int W     = 62
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    input  logic                     flush,
    output logic [W-1:0]             head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // DEPTH is a power of two, so "full" is just the top count bit alone.
    assign full    = (count == {1'b1, {AW{1'b0}}});
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Empty queue presents zeros so the head never exposes stale storage.
    assign head_dat = empty ? '0 : mem[rd_ptr];

    // Pointer and count bookkeeping; flush drops everything in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; no reset needed because empty gating hides the contents.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch: PC register, ROM addressing, prefetch queue to decode, redirect handling.
// Latency: word fetched in cycle N at head in N+1; redirect at N fetches target in N+1, valid at N+2.
// Backpressure: out_ready low fills the queue, then pc and imem_addr hold. Optional JUMP_PREDECODE_EN follows J early.
module fetch_queue_unit import mips_pkg::*; #(
    parameter int              PC_W     = PC_W_DEFAULT,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [PC_W+1:0]          imem_addr,
    input  logic [31:0]              imem_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [PC_W-1:0]          out_pc_seq,
    input  logic                     redir_valid,
    input  logic                     redir_is_jump,
    input  logic [PC_W-1:0]          redir_pc_seq,
    input  logic [15:0]              redir_imm16,
    input  logic [25:0]              redir_addr26,
    output logic [$clog2(DEPTH):0]   occupancy
);

    // PC_W must be at least 26 so a jump field always fits in the low bits.
    localparam int ENTRY_W = 32 + PC_W;

    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    next_pc;
    logic [PC_W-1:0]    branch_target;
    logic [PC_W-1:0]    jump_target;
    logic [PC_W-1:0]    redir_target;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [ENTRY_W-1:0] head_dat;

    // Replace the low 26 bits of a PC with a jump field; upper region bits come from hi.
    function automatic logic [PC_W-1:0] splice26(input logic [PC_W-1:0] hi, input logic [25:0] lo);
        logic [PC_W-1:0] t;
        t       = hi;
        t[25:0] = lo;
        return t;
    endfunction

    assign imem_addr = {pc, 2'b00};
    assign pc_inc    = pc + 1'b1;

    assign out_valid  = !empty;
    assign pop        = out_valid && out_ready;
    // A redirect cancels the word currently on the ROM bus.
    assign push       = !redir_valid && (!full || pop);

    assign out_instr  = head_dat[ENTRY_W-1:PC_W];
    assign out_pc_seq = head_dat[PC_W-1:0];

    assign branch_target = redir_pc_seq + {{(PC_W-16){redir_imm16[IMM16_HI]}}, redir_imm16};
    assign jump_target   = splice26(redir_pc_seq, redir_addr26);
    assign redir_target  = redir_is_jump ? jump_target : branch_target;

`ifdef JUMP_PREDECODE_EN
    // Follow an unconditional J straight away; the J word itself is still queued.
    assign next_pc = (imem_data[OPCODE_HI:OPCODE_LO] == OP_J)
                   ? splice26(pc, imem_data[ADDR26_HI:ADDR26_LO])
                   : pc_inc;
`else
    assign next_pc = pc_inc;
`endif

    // PC update: redirect wins, otherwise advance only when the fetched word is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redir_valid) begin
            pc <= redir_target;
        end else if (push) begin
            pc <= next_pc;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat ({imem_data, pc_inc}),
        .pop      (pop),
        .flush    (redir_valid),
        .head_dat (head_dat),
        .full     (full),
        .empty    (empty),
        .count    (occupancy)
    );

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed scenarios plus randomized traffic against a queue model.
// Latency: drives inputs just after the falling edge, samples at the next falling edge.
// Backpressure: out_ready and redirects are driven by the scenarios and by $urandom.
module tb_fetch_queue_unit;

    localparam int PC_W  = 30;
    localparam int DEPTH = 4;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [PC_W+1:0]   imem_addr;
    logic [31:0]       imem_data;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [PC_W-1:0]   out_pc_seq;
    logic              redir_valid;
    logic              redir_is_jump;
    logic [PC_W-1:0]   redir_pc_seq;
    logic [15:0]       redir_imm16;
    logic [25:0]       redir_addr26;
    logic [OW-1:0]     occupancy;

    int rom_mode = 0;
    int checks   = 0;
    int errors   = 0;

    // Reference model: program counter plus a queue of (instr, pc_seq) entries.
    logic [PC_W-1:0] m_pc;
    logic [31:0]     m_instr [$];
    logic [PC_W-1:0] m_seq   [$];

    always #5 clk = ~clk;

    // ROM: word k holds k, except mode 1 places a J to word 0x10 at word 2.
    function automatic logic [31:0] rom_word(input logic [PC_W-1:0] w, input int mode);
        if (mode == 1 && w == 2) return 32'h0800_0010;
        return {2'b00, w};
    endfunction

    assign imem_data = rom_word(imem_addr[PC_W+1:2], rom_mode);

    fetch_queue_unit #(
        .PC_W     (PC_W),
        .DEPTH    (DEPTH),
        .RESET_PC ('0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc_seq    (out_pc_seq),
        .redir_valid   (redir_valid),
        .redir_is_jump (redir_is_jump),
        .redir_pc_seq  (redir_pc_seq),
        .redir_imm16   (redir_imm16),
        .redir_addr26  (redir_addr26),
        .occupancy     (occupancy)
    );

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        out_ready     = 1'b0;
        redir_valid   = 1'b0;
        redir_is_jump = 1'b0;
        redir_pc_seq  = '0;
        redir_imm16   = '0;
        redir_addr26  = '0;
        repeat (2) @(negedge clk);
        m_pc = '0;
        m_instr.delete();
        m_seq.delete();
    endtask

    // One clock: drive inputs, advance the model by the spec rules, land on the next falling edge.
    task automatic cycle(input logic rdy, input logic rv, input logic ij,
                         input logic [PC_W-1:0] seq, input logic [15:0] imm, input logic [25:0] a26);
        logic            pop;
        logic [31:0]     w;
        logic [PC_W-1:0] nxt;
        out_ready     = rdy;
        redir_valid   = rv;
        redir_is_jump = ij;
        redir_pc_seq  = seq;
        redir_imm16   = imm;
        redir_addr26  = a26;
        pop = (m_instr.size() != 0) && rdy;
        w   = rom_word(m_pc, rom_mode);
        if (pop) begin
            void'(m_instr.pop_front());
            void'(m_seq.pop_front());
        end
        if (rv) begin
            m_instr.delete();
            m_seq.delete();
            if (ij) m_pc = {seq[PC_W-1:26], a26};
            else    m_pc = seq + {{(PC_W-16){imm[15]}}, imm};
        end else if (m_instr.size() < DEPTH) begin
            m_instr.push_back(w);
            m_seq.push_back(m_pc + 1'b1);
            nxt = m_pc + 1'b1;
`ifdef JUMP_PREDECODE_EN
            if (w[31:26] == 6'b000010) nxt = {m_pc[PC_W-1:26], w[25:0]};
`endif
            m_pc = nxt;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input logic rdy);
        cycle(rdy, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
        checks++; if (occupancy !== '0) begin errors++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", out_instr); end
        checks++; if (out_pc_seq !== '0) begin errors++; $display("FAIL reset_pc_seq: got %h expected 0", out_pc_seq); end
        checks++; if (imem_addr !== '0) begin errors++; $display("FAIL reset_imem_addr: got %h expected 0", imem_addr); end
        // Fill the queue, then pull reset between edges.
        rst_n = 1'b1;
        repeat (5) run(1'b0);
        checks++; if (occupancy !== OW'(4)) begin errors++; $display("FAIL midreset_fill: got %0d expected 4", occupancy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (occupancy !== '0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_flush: occupancy %0d valid %0b expected 0 0", occupancy, out_valid);
        end
        do_reset();
    endtask

    task automatic test_stream();
        logic [PC_W+1:0] ea;
        do_reset();
        rst_n = 1'b1;
        checks++; if (imem_addr !== '0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL stream_start: addr %h valid %0b expected 0 0", imem_addr, out_valid);
        end
        for (int k = 1; k <= 8; k++) begin
            run(1'b1);
            ea = 4 * k;
            checks++;
            if (out_valid !== 1'b1 || out_instr !== 32'(k - 1) || out_pc_seq !== PC_W'(k) || imem_addr !== ea) begin
                errors++;
                $display("FAIL stream_%0d: valid %0b instr %h seq %h addr %h expected 1 %h %h %h",
                         k, out_valid, out_instr, out_pc_seq, imem_addr, 32'(k - 1), PC_W'(k), ea);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        rst_n = 1'b1;
        repeat (10) run(1'b0);
        checks++; if (occupancy !== OW'(4)) begin errors++; $display("FAIL bp_occupancy: got %0d expected 4", occupancy); end
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL bp_pc_hold: got %h expected 10", imem_addr); end
        checks++; if (out_instr !== 32'h0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_head: instr %h valid %0b expected 0 1", out_instr, out_valid);
        end
        for (int k = 1; k <= 6; k++) begin
            run(1'b1);
            checks++;
            if (out_instr !== 32'(k) || out_pc_seq !== PC_W'(k + 1) || occupancy !== OW'(4)) begin
                errors++;
                $display("FAIL bp_drain_%0d: instr %h seq %h occ %0d expected %h %h 4",
                         k, out_instr, out_pc_seq, occupancy, 32'(k), PC_W'(k + 1));
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        rst_n = 1'b1;
        repeat (3) run(1'b0);
        checks++; if (occupancy !== OW'(3)) begin errors++; $display("FAIL br_pre_occ: got %0d expected 3", occupancy); end
        cycle(1'b0, 1'b1, 1'b0, 30'h10, 16'hFFFE, '0);
        checks++; if (occupancy !== '0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL br_flush: occ %0d valid %0b expected 0 0", occupancy, out_valid);
        end
        checks++; if (imem_addr !== 32'h38) begin errors++; $display("FAIL br_target: got %h expected 38", imem_addr); end
        run(1'b0);
        checks++; if (out_valid !== 1'b1 || out_pc_seq !== 30'h0F || out_instr !== 32'h0E) begin
            errors++; $display("FAIL br_first: valid %0b seq %h instr %h expected 1 0f 0e", out_valid, out_pc_seq, out_instr);
        end
        // Two redirects back to back: the jump in the second cycle must win.
        cycle(1'b1, 1'b1, 1'b0, 30'h100, 16'h0004, '0);
        cycle(1'b0, 1'b1, 1'b1, 30'h3FFF_FFFF, 16'h0, 26'h5);
        checks++; if (occupancy !== '0 || imem_addr !== {30'h3C00_0005, 2'b00}) begin
            errors++; $display("FAIL jmp_target: occ %0d addr %h expected 0 %h", occupancy, imem_addr, {30'h3C00_0005, 2'b00});
        end
        run(1'b0);
        checks++; if (out_instr !== 32'h3C00_0005 || out_pc_seq !== 30'h3C00_0006 || occupancy !== OW'(1)) begin
            errors++; $display("FAIL jmp_first: instr %h seq %h occ %0d expected 3c000005 3c000006 1", out_instr, out_pc_seq, occupancy);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        rst_n = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, 30'h3FFF_FFFF, 16'h0, '0);
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc: got %h expected fffffffc", imem_addr); end
        run(1'b1);
        checks++; if (out_instr !== 32'h3FFF_FFFF || out_pc_seq !== '0 || imem_addr !== '0) begin
            errors++; $display("FAIL wrap_last: instr %h seq %h addr %h expected 3fffffff 0 0", out_instr, out_pc_seq, imem_addr);
        end
        run(1'b1);
        checks++; if (out_instr !== 32'h0 || out_pc_seq !== 30'h1) begin
            errors++; $display("FAIL wrap_zero: instr %h seq %h expected 0 1", out_instr, out_pc_seq);
        end
        // Redirect while the head is being accepted.
        cycle(1'b1, 1'b1, 1'b0, 30'h20, 16'h0005, '0);
        checks++; if (occupancy !== '0 || imem_addr !== 32'h94) begin
            errors++; $display("FAIL redir_pop: occ %0d addr %h expected 0 94", occupancy, imem_addr);
        end
        run(1'b1);
        checks++; if (out_instr !== 32'h25 || out_pc_seq !== 30'h26) begin
            errors++; $display("FAIL redir_pop_next: instr %h seq %h expected 25 26", out_instr, out_pc_seq);
        end
    endtask

    task automatic test_predecode();
        logic [PC_W+1:0] exp_addr;
        logic [31:0]     exp_instr;
`ifdef JUMP_PREDECODE_EN
        exp_addr  = 32'h40;
        exp_instr = 32'h10;
`else
        exp_addr  = 32'h0C;
        exp_instr = 32'h3;
`endif
        rom_mode = 1;
        do_reset();
        rst_n = 1'b1;
        checks++; if (imem_addr !== '0) begin errors++; $display("FAIL pd_addr0: got %h expected 0", imem_addr); end
        run(1'b1);
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL pd_addr1: got %h expected 4", imem_addr); end
        run(1'b1);
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL pd_addr2: got %h expected 8", imem_addr); end
        run(1'b1);
        checks++; if (imem_addr !== exp_addr) begin errors++; $display("FAIL pd_addr3: got %h expected %h", imem_addr, exp_addr); end
        checks++; if (out_instr !== 32'h0800_0010 || out_pc_seq !== 30'h3) begin
            errors++; $display("FAIL pd_j_entry: instr %h seq %h expected 08000010 3", out_instr, out_pc_seq);
        end
        run(1'b1);
        checks++; if (out_instr !== exp_instr || out_pc_seq !== PC_W'(exp_instr + 1)) begin
            errors++; $display("FAIL pd_after_j: instr %h seq %h expected %h %h", out_instr, out_pc_seq, exp_instr, exp_instr + 1);
        end
        rom_mode = 0;
    endtask

    task automatic test_random();
        logic            rdy;
        logic            rv;
        logic            ij;
        logic [PC_W-1:0] seq;
        logic [15:0]     imm;
        logic [25:0]     a26;
        do_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 600; i++) begin
            rdy = ($urandom_range(0, 2) != 0);
            rv  = ($urandom_range(0, 9) == 0);
            ij  = $urandom_range(0, 1) == 1;
            seq = PC_W'($urandom());
            imm = 16'($urandom());
            a26 = 26'($urandom());
            cycle(rdy, rv, ij, seq, imm, a26);
            checks++; if (imem_addr !== {m_pc, 2'b00}) begin
                errors++; $display("FAIL rnd_addr @%0d: got %h expected %h", i, imem_addr, {m_pc, 2'b00});
            end
            checks++; if (occupancy !== OW'(m_instr.size()) || out_valid !== (m_instr.size() != 0)) begin
                errors++; $display("FAIL rnd_occ @%0d: occ %0d valid %0b expected %0d", i, occupancy, out_valid, m_instr.size());
            end
            if (m_instr.size() != 0) begin
                checks++; if (out_instr !== m_instr[0] || out_pc_seq !== m_seq[0]) begin
                    errors++; $display("FAIL rnd_head @%0d: instr %h seq %h expected %h %h", i, out_instr, out_pc_seq, m_instr[0], m_seq[0]);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_predecode();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
